// File: rtl/result_unpacker_if.sv
// result_unpacker_if
//   Bundles the word-side and element-side handshakes of result_unpacker.
//   Optional: UNPACK_LAST_EN adds last_o (final element of a channel group).
//   Signals:
//     in_data  packed word (READ_WIDTH bits), element 0 in the most significant slot
//     valid_i  in_data valid
//     ready_o  unpacker can take a word this cycle
//     out      current element (RESULT_BIT bits)
//     valid_o  out valid
//     ready_i  consumer takes out this cycle
//     last_o   out is the final element of its group (UNPACK_LAST_EN only)
//   Modports:
//     slave    the unpacker itself
//     master   the surrounding system (word producer + element consumer)
interface result_unpacker_if #(
  parameter int RESULT_BIT = 8,
  parameter int READ_WIDTH = 128
);
  logic [READ_WIDTH-1:0] in_data;
  logic                  valid_i;
  logic                  ready_o;
  logic [RESULT_BIT-1:0] out;
  logic                  valid_o;
  logic                  ready_i;
`ifdef UNPACK_LAST_EN
  logic                  last_o;
`endif

`ifdef UNPACK_LAST_EN
  modport slave  (input  in_data, valid_i, ready_i,
                  output ready_o, out, valid_o, last_o);
  modport master (output in_data, valid_i, ready_i,
                  input  ready_o, out, valid_o, last_o);
`else
  modport slave  (input  in_data, valid_i, ready_i,
                  output ready_o, out, valid_o);
  modport master (output in_data, valid_i, ready_i,
                  input  ready_o, out, valid_o);
`endif
endinterface

// File: rtl/result_unpacker.sv
// result_unpacker
//   Splits packed READ_WIDTH-bit words into RESULT_BIT-bit elements, one element
//   per cycle, grouped into channel groups of out_chan_size elements. Every word
//   of a group is full (EPW elements) except the final one, which carries only
//   the remaining elements in its low bits; its unused upper bits are dropped.
//   Optional: define UNPACK_LAST_EN to get last_o on the final element of a group.
//   Ports:
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset
//     out_chan_size  elements per group (0 = MAX_CHAN), sampled on the first
//                    word of each group
//     bus            result_unpacker_if.slave (word in, element out handshakes)
module result_unpacker #(
  parameter int RESULT_BIT = 8,
  parameter int READ_WIDTH = 128,
  parameter int MAX_CHAN   = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(MAX_CHAN)-1:0] out_chan_size,
  result_unpacker_if.slave            bus
);

  localparam int EPW = READ_WIDTH / RESULT_BIT;
  localparam int CW  = $clog2(MAX_CHAN);
  // One extra bit so a full MAX_CHAN group size is representable.
  localparam int NW  = CW + 1;
  localparam int KW  = $clog2(EPW + 1);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_CHAN);
  localparam logic [NW-1:0] EPW_N = NW'(EPW);
  localparam logic [KW-1:0] EPW_K = KW'(EPW);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, next_state;

  logic [READ_WIDTH-1:0] word_buf;
  logic [KW-1:0]         elem_left;
  logic [NW-1:0]         chan_cnt;
  logic [NW-1:0]         grp_size;
`ifdef UNPACK_LAST_EN
  logic                  word_final;
`endif

  logic                  valid_int;
  logic                  ready_int;
  logic                  elem_last;
  logic                  accept;
  logic                  consume;
  logic [NW-1:0]         size_eff;
  logic [NW-1:0]         chan_left;
  logic [NW-1:0]         chan_next;
  logic [KW-1:0]         word_k;
  logic [READ_WIDTH-1:0] load_word;

  assign elem_last = (elem_left == KW'(1));
  assign accept    = bus.valid_i && ready_int;
  assign consume   = valid_int && bus.ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A new word is only taken while nothing is held, or in the same cycle the
  // last element of the held word leaves, which gives back-to-back words.
  always_comb begin
    next_state = state;
    valid_int  = 1'b0;
    ready_int  = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (bus.valid_i) begin
          next_state = EMIT;
        end
      end
      EMIT: begin
        valid_int = 1'b1;
        ready_int = bus.ready_i && elem_last;
        if (bus.ready_i && elem_last && !bus.valid_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // chan_cnt counts elements already loaded in the current group; zero means
  // the next accepted word opens a new group and samples out_chan_size.
  // The word size is decided from how many group elements are still unloaded.
  always_comb begin
    size_eff = grp_size;
    if (chan_cnt == '0) begin
      size_eff = (out_chan_size == '0) ? MAX_N : {1'b0, out_chan_size};
    end
    chan_left = size_eff - chan_cnt;
    word_k    = (chan_left >= EPW_N) ? EPW_K : chan_left[KW-1:0];
    chan_next = chan_cnt + NW'(word_k);
    // Left-align a partial word so element 0 always sits in the top slot and
    // the unused upper bits fall off the end.
    load_word = bus.in_data << (RESULT_BIT * (EPW - int'(word_k)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf   <= '0;
      elem_left  <= '0;
      chan_cnt   <= '0;
      grp_size   <= '0;
`ifdef UNPACK_LAST_EN
      word_final <= 1'b0;
`endif
    end else if (accept) begin
      word_buf   <= load_word;
      elem_left  <= word_k;
      grp_size   <= size_eff;
      chan_cnt   <= (chan_next == size_eff) ? '0 : chan_next;
`ifdef UNPACK_LAST_EN
      word_final <= (chan_next == size_eff);
`endif
    end else if (consume) begin
      word_buf   <= word_buf << RESULT_BIT;
      elem_left  <= elem_left - KW'(1);
    end
  end

  assign bus.out     = word_buf[READ_WIDTH-1 -: RESULT_BIT];
  assign bus.valid_o = valid_int;
  assign bus.ready_o = ready_int;
`ifdef UNPACK_LAST_EN
  assign bus.last_o  = valid_int && elem_last && word_final;
`endif

endmodule
